// File: rtl/huffman_bit_packer.sv
// Huffman code-table capture and MSB-first bit packer with valid/ready byte output.
// Optional macro HUFF_PACK_ERR_EN adds the sticky err_unknown_o flag.
module huffman_bit_packer #(
  parameter int bit_width  = 7,
  parameter int max_symbol = 255
) (
  input  logic               clock_i,
  input  logic               rst_i,
  input  logic               tbl_valid_i,
  input  logic [bit_width:0] tbl_symbol_i,
  input  logic [3:0]         tbl_length_i,
  input  logic [bit_width:0] tbl_code_i,
  input  logic               tbl_done_i,
  input  logic               sym_valid_i,
  input  logic [bit_width:0] sym_data_i,
  input  logic               sym_last_i,
  output logic               sym_ready_o,
  output logic               byte_valid_o,
  output logic [7:0]         byte_data_o,
  output logic               byte_last_o,
  output logic [2:0]         pad_bits_o,
  input  logic               byte_ready_i,
  output logic               done_o,
  output logic [2:0]         out_state_o
`ifdef HUFF_PACK_ERR_EN
  ,output logic              err_unknown_o
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ENCODE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [3:0]          lenTable_q  [0:max_symbol];
  logic [bit_width:0]  codeTable_q [0:max_symbol];
  logic [max_symbol:0] entryValid_q;
  logic [15:0]         acc_q, acc_d;
  logic [4:0]          accCnt_q, accCnt_d;
  logic                byteValid_q, byteLast_q, done_q;
  logic [7:0]          byteData_q;
  logic [2:0]          padBits_q;

  logic        symReady, accept, slotFree, emitFull, hit, tblLegal, tblWrite;
  logic [3:0]  appendLen;
  logic [7:0]  appendBits;
  logic [15:0] shifted;
  logic [4:0]  baseCnt;

  // Emit (shift out the top byte) happens before the new code lands, so the
  // append position is computed from the post-shift bit count.
  always_comb begin
    symReady   = (state_q == ENCODE) && (accCnt_q <= 5'd8);
    accept     = sym_valid_i && symReady;
    slotFree   = !byteValid_q || byte_ready_i;
    emitFull   = (accCnt_q >= 5'd8) && slotFree;
    hit        = entryValid_q[sym_data_i];
    appendLen  = (accept && hit) ? lenTable_q[sym_data_i] : 4'd0;
    appendBits = codeTable_q[sym_data_i] & (8'hFF >> (4'd8 - appendLen));
    shifted    = emitFull ? {acc_q[7:0], 8'h00} : acc_q;
    baseCnt    = emitFull ? (accCnt_q - 5'd8) : accCnt_q;
    acc_d      = shifted | ({8'h00, appendBits} << (5'd16 - baseCnt - {1'b0, appendLen}));
    accCnt_d   = baseCnt + {1'b0, appendLen};
    tblLegal   = (tbl_length_i != 4'd0) && (tbl_length_i <= 4'd8);
    tblWrite   = tbl_valid_i && tblLegal && ((state_q == IDLE) || (state_q == LOAD));
  end

  always_ff @(posedge clock_i) begin
    if (tblWrite) begin
      lenTable_q[tbl_symbol_i]  <= tbl_length_i;
      codeTable_q[tbl_symbol_i] <= tbl_code_i;
    end
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      entryValid_q <= '0;
      acc_q        <= '0;
      accCnt_q     <= '0;
      byteValid_q  <= 1'b0;
      byteData_q   <= '0;
      byteLast_q   <= 1'b0;
      padBits_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tbl_valid_i) begin
            entryValid_q <= tblLegal ? ({{max_symbol{1'b0}}, 1'b1} << tbl_symbol_i) : '0;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (tbl_valid_i && tblLegal) entryValid_q[tbl_symbol_i] <= 1'b1;
          if (tbl_done_i) state_q <= ENCODE;
        end
        ENCODE: begin
          acc_q    <= acc_d;
          accCnt_q <= accCnt_d;
          if (emitFull) begin
            byteValid_q <= 1'b1;
            byteData_q  <= acc_q[15:8];
            byteLast_q  <= accept && sym_last_i && (accCnt_d == 5'd0);
            padBits_q   <= '0;
          end else if (byteValid_q && byte_ready_i) begin
            byteValid_q <= 1'b0;
            byteLast_q  <= 1'b0;
          end
          if (accept && sym_last_i) state_q <= FLUSH;
        end
        FLUSH: begin
          if (slotFree) begin
            if (accCnt_q >= 5'd8) begin
              byteValid_q <= 1'b1;
              byteData_q  <= acc_q[15:8];
              byteLast_q  <= (accCnt_q == 5'd8);
              padBits_q   <= '0;
              acc_q       <= {acc_q[7:0], 8'h00};
              accCnt_q    <= accCnt_q - 5'd8;
            end else if (accCnt_q != 5'd0) begin
              byteValid_q <= 1'b1;
              byteData_q  <= acc_q[15:8];
              byteLast_q  <= 1'b1;
              padBits_q   <= 3'(5'd8 - accCnt_q);
              acc_q       <= '0;
              accCnt_q    <= '0;
            end else begin
              byteValid_q <= 1'b0;
              byteLast_q  <= 1'b0;
              padBits_q   <= '0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HUFF_PACK_ERR_EN
  logic errUnknown_q;

  // Sticky until the next table load begins; the first entry of a load can itself set it.
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      errUnknown_q <= 1'b0;
    end else if (state_q == IDLE && tbl_valid_i) begin
      errUnknown_q <= !tblLegal;
    end else if ((state_q == LOAD && tbl_valid_i && !tblLegal) || (accept && !hit)) begin
      errUnknown_q <= 1'b1;
    end
  end

  assign err_unknown_o = errUnknown_q;
`endif

  assign sym_ready_o  = symReady;
  assign byte_valid_o = byteValid_q;
  assign byte_data_o  = byteData_q;
  assign byte_last_o  = byteLast_q;
  assign pad_bits_o   = padBits_q;
  assign done_o       = done_q;
  assign out_state_o  = state_q;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: a bit-queue model checks every byte handshake,
// and literal per-test byte logs pin the model.
module tb_huffman_bit_packer;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       tblValid = 1'b0, tblDone = 1'b0;
  logic [7:0] tblSymbol = '0, tblCode = '0;
  logic [3:0] tblLength = '0;
  logic       symValid = 1'b0, symLast = 1'b0;
  logic [7:0] symData = '0;
  logic       symReady, byteValid, byteLast, done;
  logic [7:0] byteData;
  logic [2:0] padBits, outState;
  logic       byteReady = 1'b1;
`ifdef HUFF_PACK_ERR_EN
  logic       errUnknown;
`endif

  huffman_bit_packer dut (
    .clock_i      (clock),
    .rst_i        (rst),
    .tbl_valid_i  (tblValid),
    .tbl_symbol_i (tblSymbol),
    .tbl_length_i (tblLength),
    .tbl_code_i   (tblCode),
    .tbl_done_i   (tblDone),
    .sym_valid_i  (symValid),
    .sym_data_i   (symData),
    .sym_last_i   (symLast),
    .sym_ready_o  (symReady),
    .byte_valid_o (byteValid),
    .byte_data_o  (byteData),
    .byte_last_o  (byteLast),
    .pad_bits_o   (padBits),
    .byte_ready_i (byteReady),
    .done_o       (done),
    .out_state_o  (outState)
`ifdef HUFF_PACK_ERR_EN
    ,.err_unknown_o (errUnknown)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: table contents plus the ordered stream of code bits not yet seen in a byte.
  logic [3:0]  mLen  [256];
  logic [7:0]  mCode [256];
  bit          mValid[256];
  bit          mBits[$];
  bit          streamEnded = 0;
  bit          tableFresh = 1;
  logic [11:0] logQ[$];
  bit          heldPrev = 0;
  logic [11:0] heldWord = '0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    int          n, take;
    logic [7:0]  d;
    bit          expLast;
    if (rst) begin
      heldPrev = 0;
    end else begin
      if (outState != 3'd2) checkOutput("sym_ready_outside_encode", symReady, 0);
      if (heldPrev) begin
        checkOutput("hold_valid", byteValid, 1);
        checkOutput("hold_word", {byteLast, padBits, byteData}, heldWord);
      end
      if (byteValid && byteReady) begin
        n    = mBits.size();
        take = (n < 8) ? n : 8;
        d    = '0;
        checkOutput("byte_bits_available", int'(n > 0), 1);
        for (int i = 0; i < take; i++) d[7-i] = mBits.pop_front();
        expLast = streamEnded && (mBits.size() == 0);
        checkOutput("byte_data", byteData, d);
        checkOutput("byte_last", byteLast, int'(expLast));
        checkOutput("pad_bits", padBits, expLast ? 8 - take : 0);
        logQ.push_back({byteLast, padBits, byteData});
      end
      heldPrev = byteValid && !byteReady;
      heldWord = {byteLast, padBits, byteData};
      if (symValid && symReady) begin
        if (mValid[symData])
          for (int i = int'(mLen[symData]) - 1; i >= 0; i--) mBits.push_back(mCode[symData][i]);
        if (symLast) streamEnded = 1;
      end
    end
  end

  task automatic startStream();
    mBits.delete();
    logQ.delete();
    streamEnded = 0;
    tableFresh  = 1;
  endtask

  task automatic loadEntry(input logic [7:0] s, input logic [3:0] l, input logic [7:0] c, input bit withDone);
    tblValid = 1'b1; tblSymbol = s; tblLength = l; tblCode = c; tblDone = withDone;
    if (tableFresh) begin
      for (int i = 0; i < 256; i++) mValid[i] = 0;
      tableFresh = 0;
    end
    if (l >= 4'd1 && l <= 4'd8) begin
      mValid[s] = 1; mLen[s] = l; mCode[s] = c;
    end
    @(posedge clock); #1;
    tblValid = 1'b0; tblDone = 1'b0;
  endtask

  task automatic tableDone();
    tblDone = 1'b1;
    @(posedge clock); #1;
    tblDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic last);
    int waitCnt = 0;
    symValid = 1'b1; symData = s; symLast = last;
    do begin
      @(negedge clock);
      waitCnt++;
    end while (!symReady && waitCnt < 200);
    checkOutput("sym_accept_timeout", symReady, 1);
    @(posedge clock); #1;
    symValid = 1'b0; symLast = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!done && c < 400);
    checkOutput({name, "_done_seen"}, done, 1);
    checkOutput({name, "_model_drained"}, mBits.size(), 0);
    @(negedge clock);
    checkOutput({name, "_done_width"}, done, 0);
    checkOutput({name, "_back_to_idle"}, outState, 0);
    @(posedge clock); #1;
  endtask

  task automatic expectByte(input string name, input int idx, input logic [11:0] word);
    logic [11:0] got;
    got = (idx < logQ.size()) ? logQ[idx] : 12'hFFF;
    checkOutput(name, got, word);
  endtask

  task automatic runAbcTest(input string name);
    startStream();
    loadEntry(8'h41, 4'd1, 8'h00, 0);
    loadEntry(8'h42, 4'd2, 8'h02, 0);
    loadEntry(8'h43, 4'd2, 8'h03, 0);
    tableDone();
    applyStimulus(8'h41, 0);
    applyStimulus(8'h42, 0);
    applyStimulus(8'h43, 0);
    applyStimulus(8'h41, 1);
    waitDone(name);
    checkOutput({name, "_byte_count"}, logQ.size(), 1);
    expectByte({name, "_byte0"}, 0, 12'hA58);
  endtask

  initial begin
    #1;
    checkOutput("reset_byte_valid", byteValid, 0);
    checkOutput("reset_state", outState, 0);
    checkOutput("reset_sym_ready", symReady, 0);
    checkOutput("reset_done", done, 0);
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(posedge clock); #1;

    runAbcTest("abc");
`ifdef HUFF_PACK_ERR_EN
    checkOutput("abc_err", errUnknown, 0);
`endif

    // Back-pressure: three full bytes with the consumer stalled.
    startStream();
    byteReady = 1'b0;
    loadEntry(8'h41, 4'd8, 8'hA5, 0);
    tableDone();
    applyStimulus(8'h41, 0);
    applyStimulus(8'h41, 0);
    applyStimulus(8'h41, 1);
    checkOutput("stall_sym_ready", symReady, 0);
    checkOutput("stall_state_flush", outState, 3);
    checkOutput("stall_byte_valid", byteValid, 1);
    checkOutput("stall_byte_data", byteData, 8'hA5);
    repeat (5) @(posedge clock);
    #1 byteReady = 1'b1;
    waitDone("stall");
    checkOutput("stall_byte_count", logQ.size(), 3);
    expectByte("stall_byte0", 0, 12'h0A5);
    expectByte("stall_byte1", 1, 12'h0A5);
    expectByte("stall_byte2", 2, 12'h8A5);

    // Codes straddling a byte boundary; last entry arrives with tbl_done.
    startStream();
    loadEntry(8'h10, 4'd8, 8'hFF, 0);
    loadEntry(8'h11, 4'd4, 8'h00, 1);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h11, 1);
    waitDone("straddle");
    checkOutput("straddle_byte_count", logQ.size(), 2);
    expectByte("straddle_byte0", 0, 12'h00F);
    expectByte("straddle_byte1", 1, 12'h8F0);

    // Unknown symbol contributes no bits.
    startStream();
    loadEntry(8'h41, 4'd1, 8'h01, 0);
    tableDone();
    applyStimulus(8'h99, 0);
    applyStimulus(8'h41, 1);
    waitDone("unknown");
    checkOutput("unknown_byte_count", logQ.size(), 1);
    expectByte("unknown_byte0", 0, 12'hF80);
`ifdef HUFF_PACK_ERR_EN
    checkOutput("unknown_err", errUnknown, 1);
`endif

    // Illegal lengths are dropped, leaving an empty stream.
    startStream();
    loadEntry(8'h20, 4'd0, 8'h01, 0);
    loadEntry(8'h20, 4'd9, 8'h01, 0);
    tableDone();
    applyStimulus(8'h20, 1);
    waitDone("illegal");
    checkOutput("illegal_byte_count", logQ.size(), 0);
`ifdef HUFF_PACK_ERR_EN
    checkOutput("illegal_err", errUnknown, 1);
`endif

    // Asynchronous reset with a byte pending.
    startStream();
    byteReady = 1'b0;
    loadEntry(8'h41, 4'd8, 8'hA5, 0);
    tableDone();
    applyStimulus(8'h41, 0);
    applyStimulus(8'h41, 0);
    checkOutput("prereset_byte_valid", byteValid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_byte_valid", byteValid, 0);
    checkOutput("async_byte_data", byteData, 0);
    checkOutput("async_byte_last", byteLast, 0);
    checkOutput("async_pad_bits", padBits, 0);
    checkOutput("async_state", outState, 0);
    checkOutput("async_sym_ready", symReady, 0);
    checkOutput("async_done", done, 0);
    startStream();
    byteReady = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    symValid = 1'b1; symData = 8'h41;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("postreset_sym_ready", symReady, 0);
      checkOutput("postreset_byte_valid", byteValid, 0);
    end
    @(posedge clock); #1;
    symValid = 1'b0;

    runAbcTest("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
